// File: rtl/serial_pair_arbiter_pkg.sv
// Shared types and default sizing for the serial pair arbiter.
package serial_pair_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_CNT_W   = 8;

  // Arbiter control states: wait for a request, stream the granted
  // channel through the detector, then publish the result for one cycle.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_STREAM,
    ARB_REPORT
  } arb_state_t;

endpackage

// File: rtl/ones_pair_detector.sv
// Mealy detector for two consecutive accepted ones. The state remembers
// whether the previous accepted bit was a one; clr restarts the sequence.
module ones_pair_detector
  import serial_pair_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic in,
  output logic hit
);

  logic prev_one_q;
  logic prev_one_d;

  // Next state: clear wins, accepted bits update, idle cycles hold.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    prev_one_d = prev_one_q;
    if (clr) begin
      prev_one_d = 1'b0;
    end else if (en) begin
      prev_one_d = in;
    end
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_one_q <= 1'b0;
    end else begin
      prev_one_q <= prev_one_d;
    end
  end

  // Mealy output: a hit is reported in the same cycle as the second one.
  assign hit = en & in & prev_one_q;

endmodule

// File: rtl/serial_pair_arbiter.sv
// Round-robin arbiter that lends one shared consecutive-ones detector to a
// single requester at a time and reports the per-stream hit count.
module serial_pair_arbiter
  import serial_pair_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = DEFAULT_NUM_REQ,
  parameter int  CNT_W   = DEFAULT_CNT_W,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] valid,
  input  logic [NUM_REQ-1:0] bit_in,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic [CNT_W-1:0]   pair_count,
  output logic               aborted
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    grant_idx_q, grant_idx_d;
  logic [ID_W-1:0]    last_winner_q, last_winner_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   pair_count_q, pair_count_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic               aborted_q, aborted_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    cand;
  logic               det_clr;
  logic               det_en;
  logic               det_hit;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_winner_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Detector controls are kept out of the FSM block so the Mealy hit path
  // does not feed back into the process that drives it.
  assign det_clr = (state_q == ARB_IDLE) && win_found;
  assign det_en  = (state_q == ARB_STREAM) && req[grant_idx_q] && valid[grant_idx_q];

  ones_pair_detector u_detector (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .in  (bit_in[grant_idx_q]),
    .hit (det_hit)
  );

  // FSM next state, grant, hit counting and result capture.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    grant_idx_d   = grant_idx_q;
    last_winner_d = last_winner_q;
    count_d       = count_q;
    pair_count_d  = pair_count_q;
    done_id_d     = done_id_q;
    aborted_d     = aborted_q;

    case (state_q)
      ARB_IDLE: begin
        if (win_found) begin
          state_d     = ARB_STREAM;
          gnt_d       = NUM_REQ'(1) << win_idx;
          grant_idx_d = win_idx;
          count_d     = '0;
        end
      end

      ARB_STREAM: begin
        if (!req[grant_idx_q]) begin
          // Requester walked away: report what was counted, drop this bit.
          state_d      = ARB_REPORT;
          gnt_d        = '0;
          pair_count_d = count_q;
          done_id_d    = grant_idx_q;
          aborted_d    = 1'b1;
        end else if (valid[grant_idx_q]) begin
          if (det_hit && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
          end
          if (last[grant_idx_q]) begin
            state_d      = ARB_REPORT;
            gnt_d        = '0;
            pair_count_d = count_d;
            done_id_d    = grant_idx_q;
            aborted_d    = 1'b0;
          end
        end
      end

      ARB_REPORT: begin
        state_d       = ARB_IDLE;
        last_winner_d = grant_idx_q;
      end

      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      gnt_q         <= '0;
      grant_idx_q   <= '0;
      last_winner_q <= ID_W'(NUM_REQ - 1);
      count_q       <= '0;
      pair_count_q  <= '0;
      done_id_q     <= '0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      grant_idx_q   <= grant_idx_d;
      last_winner_q <= last_winner_d;
      count_q       <= count_d;
      pair_count_q  <= pair_count_d;
      done_id_q     <= done_id_d;
      aborted_q     <= aborted_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != ARB_IDLE);
  assign done       = (state_q == ARB_REPORT);
  assign done_id    = done_id_q;
  assign pair_count = pair_count_q;
  assign aborted    = aborted_q;

endmodule
